// File: rtl/bcd_operand_entry_if.sv
// Operand-entry bus: switch/button inputs toward the entry block and the
// registered operand set toward the adder/display stage.
// Optional backspace input is present only when BCD_ENTRY_BACKSPACE_EN is defined.
interface bcd_operand_entry_if;
  logic [3:0] DIGIT_IN;
  logic       OP_IN;
  logic       LOAD_N;
`ifdef BCD_ENTRY_BACKSPACE_EN
  logic       DEL_N;
`endif
  logic [3:0] A_TENS;
  logic [3:0] A_ONES;
  logic [3:0] B_TENS;
  logic [3:0] B_ONES;
  logic       OPERATOR;
  logic       OPERANDS_VALID;
  logic       START;
  logic       DIGIT_ERR;
  logic [2:0] ENTRY_STATE;

`ifdef BCD_ENTRY_BACKSPACE_EN
  modport master (
    output DIGIT_IN, OP_IN, LOAD_N, DEL_N,
    input  A_TENS, A_ONES, B_TENS, B_ONES, OPERATOR, OPERANDS_VALID,
           START, DIGIT_ERR, ENTRY_STATE
  );
  modport slave (
    input  DIGIT_IN, OP_IN, LOAD_N, DEL_N,
    output A_TENS, A_ONES, B_TENS, B_ONES, OPERATOR, OPERANDS_VALID,
           START, DIGIT_ERR, ENTRY_STATE
  );
`else
  modport master (
    output DIGIT_IN, OP_IN, LOAD_N,
    input  A_TENS, A_ONES, B_TENS, B_ONES, OPERATOR, OPERANDS_VALID,
           START, DIGIT_ERR, ENTRY_STATE
  );
  modport slave (
    input  DIGIT_IN, OP_IN, LOAD_N,
    output A_TENS, A_ONES, B_TENS, B_ONES, OPERATOR, OPERANDS_VALID,
           START, DIGIT_ERR, ENTRY_STATE
  );
`endif
endinterface

// File: rtl/bcd_operand_entry.sv
// Keyed entry of two 2-digit BCD operands (A tens, A ones, B tens, B ones)
// plus operator, one digit per debounced button press.
// Optional feature macro: BCD_ENTRY_BACKSPACE_EN adds a DEL_N backspace button.

// Synchroniser + debouncer for an active-low button; one-cycle press event.
module bcd_entry_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw_n_i,
  output logic press_evt_o
);
  localparam int unsigned CNT_W = 16;

  logic [1:0]       sync_q;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             evt_q;

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == DEBOUNCE_CYCLES - CNT_W'(1)) stable_d = sync_q[1];
      else                                      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser, debounce state and registered falling-edge event.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q       <= 2'b11;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      cnt_q        <= '0;
      evt_q        <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], raw_n_i};
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
      evt_q        <= stable_dly_q & ~stable_q;
    end
  end

  assign press_evt_o = evt_q;
endmodule

module bcd_operand_entry #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  bcd_operand_entry_if.slave    bus
);
  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [2:0] {
    S_A_T   = 3'd0,
    S_A_O   = 3'd1,
    S_B_T   = 3'd2,
    S_B_O   = 3'd3,
    S_READY = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [DIGIT_W-1:0]   a_tens_q, a_tens_d, a_ones_q, a_ones_d;
  logic [DIGIT_W-1:0]   b_tens_q, b_tens_d, b_ones_q, b_ones_d;
  logic                 op_q, op_d;
  logic                 valid_q, valid_d;
  logic                 start_q, start_d;
  logic                 err_q, err_d;
  logic [DIGIT_W-1:0]   digit_s1_q, digit_s2_q;
  logic                 op_s1_q, op_s2_q;
  logic                 load_evt;
  logic                 digit_ok;
  logic                 state_legal;

  bcd_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk_i      (CLOCK_50),
    .rst_n_i    (RESET_N),
    .raw_n_i    (bus.LOAD_N),
    .press_evt_o(load_evt)
  );

`ifdef BCD_ENTRY_BACKSPACE_EN
  logic del_evt;

  bcd_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_del_db (
    .clk_i      (CLOCK_50),
    .rst_n_i    (RESET_N),
    .raw_n_i    (bus.DEL_N),
    .press_evt_o(del_evt)
  );
`endif

  assign digit_ok    = (digit_s2_q <= DIGIT_W'(9));
  assign state_legal = (state_q <= S_READY);

  // Next state and operand registers; load beats backspace in the same cycle.
  always_comb begin
    state_d  = state_q;
    a_tens_d = a_tens_q;
    a_ones_d = a_ones_q;
    b_tens_d = b_tens_q;
    b_ones_d = b_ones_q;
    op_d     = op_q;
    err_d    = 1'b0;
    if (!state_legal) begin
      state_d = S_A_T;
    end else if (load_evt) begin
      if (state_q == S_READY) begin
        a_tens_d = '0;
        a_ones_d = '0;
        b_tens_d = '0;
        b_ones_d = '0;
        op_d     = 1'b0;
        state_d  = S_A_T;
      end else if (!digit_ok) begin
        err_d = 1'b1;
      end else begin
        case (state_q)
          S_A_T:   begin a_tens_d = digit_s2_q; state_d = S_A_O; end
          S_A_O:   begin a_ones_d = digit_s2_q; state_d = S_B_T; end
          S_B_T:   begin b_tens_d = digit_s2_q; state_d = S_B_O; end
          S_B_O:   begin b_ones_d = digit_s2_q; op_d = op_s2_q; state_d = S_READY; end
          default: state_d = S_A_T;
        endcase
      end
    end
`ifdef BCD_ENTRY_BACKSPACE_EN
    else if (del_evt) begin
      case (state_q)
        S_A_O:   begin a_tens_d = '0; state_d = S_A_T; end
        S_B_T:   begin a_ones_d = '0; state_d = S_A_O; end
        S_B_O:   begin b_tens_d = '0; state_d = S_B_T; end
        S_READY: begin b_ones_d = '0; op_d = 1'b0; state_d = S_B_O; end
        default: state_d = state_q;
      endcase
    end
`endif
    valid_d = (state_d == S_READY);
    start_d = valid_d && (state_q != S_READY);
  end

  // State, operand and status registers plus switch synchronisers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_A_T;
      a_tens_q   <= '0;
      a_ones_q   <= '0;
      b_tens_q   <= '0;
      b_ones_q   <= '0;
      op_q       <= 1'b0;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
      digit_s1_q <= '1;
      digit_s2_q <= '1;
      op_s1_q    <= 1'b1;
      op_s2_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      a_tens_q   <= a_tens_d;
      a_ones_q   <= a_ones_d;
      b_tens_q   <= b_tens_d;
      b_ones_q   <= b_ones_d;
      op_q       <= op_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      err_q      <= err_d;
      digit_s1_q <= bus.DIGIT_IN;
      digit_s2_q <= digit_s1_q;
      op_s1_q    <= bus.OP_IN;
      op_s2_q    <= op_s1_q;
    end
  end

  assign bus.A_TENS         = a_tens_q;
  assign bus.A_ONES         = a_ones_q;
  assign bus.B_TENS         = b_tens_q;
  assign bus.B_ONES         = b_ones_q;
  assign bus.OPERATOR       = op_q;
  assign bus.OPERANDS_VALID = valid_q;
  assign bus.START          = start_q;
  assign bus.DIGIT_ERR      = err_q;
  assign bus.ENTRY_STATE    = state_q;
endmodule

// File: tb/tb_bcd_operand_entry.sv
// Directed bench for bcd_operand_entry with a short debounce window.
module tb_bcd_operand_entry;
  localparam logic [15:0] DC  = 16'd4;
  localparam int          DCI = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_operand_entry_if bus();

  bcd_operand_entry #(.DEBOUNCE_CYCLES(DC)) dut (
    .CLOCK_50(clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  int chg_cnt = 0;
  logic [2:0] prev_state = 3'd0;

  // Count START/DIGIT_ERR high cycles and state changes, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && bus.START)     start_cnt++;
    if (rst_n && bus.DIGIT_ERR) err_cnt++;
    if (bus.ENTRY_STATE != prev_state) chg_cnt++;
    prev_state = bus.ENTRY_STATE;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] digits();
    return {bus.A_TENS, bus.A_ONES, bus.B_TENS, bus.B_ONES};
  endfunction

  // Clean press: hold low well past the debounce window, then release.
  task automatic press(input logic [3:0] d, input logic op);
    @(negedge clk);
    bus.DIGIT_IN = d;
    bus.OP_IN    = op;
    bus.LOAD_N   = 1'b0;
    cycles(12);
    bus.LOAD_N   = 1'b1;
    cycles(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, s0, e0, n;
    rst_n        = 1'b0;
    bus.DIGIT_IN = 4'd0;
    bus.OP_IN    = 1'b0;
    bus.LOAD_N   = 1'b1;
`ifdef BCD_ENTRY_BACKSPACE_EN
    bus.DEL_N    = 1'b1;
`endif
    cycles(3);
    check("rst_state",  32'(bus.ENTRY_STATE), 32'd0);
    check("rst_digits", 32'(digits()), 32'h0);
    check("rst_op",     32'(bus.OPERATOR), 32'd0);
    check("rst_valid",  32'(bus.OPERANDS_VALID), 32'd0);
    check("rst_start",  32'(bus.START), 32'd0);
    check("rst_err",    32'(bus.DIGIT_ERR), 32'd0);
    rst_n = 1'b1;
    cycles(3);

    // Basic entry 37 + 25
    s0 = start_cnt;
    press(4'd3, 1'b0);
    check("adv_a_t", 32'(bus.ENTRY_STATE), 32'd1);
    press(4'd7, 1'b0);
    press(4'd2, 1'b0);
    press(4'd5, 1'b0);
    check("e1_digits", 32'(digits()), 32'h3725);
    check("e1_op",     32'(bus.OPERATOR), 32'd0);
    check("e1_valid",  32'(bus.OPERANDS_VALID), 32'd1);
    check("e1_state",  32'(bus.ENTRY_STATE), 32'd4);
    check("e1_start",  32'(start_cnt - s0), 32'd1);

    // Press in READY clears everything
    press(4'd6, 1'b1);
    check("clr_state",  32'(bus.ENTRY_STATE), 32'd0);
    check("clr_digits", 32'(digits()), 32'h0);
    check("clr_valid",  32'(bus.OPERANDS_VALID), 32'd0);

    // Bounce 2-low/2-high for 20 cycles, then hold low
    c0 = chg_cnt;
    @(negedge clk);
    bus.DIGIT_IN = 4'd6;
    for (int i = 0; i < 5; i++) begin
      bus.LOAD_N = 1'b0;
      cycles(2);
      bus.LOAD_N = 1'b1;
      cycles(2);
    end
    check("bounce_noevt", 32'(chg_cnt - c0), 32'd0);
    bus.LOAD_N = 1'b0;
    n = 0;
    // Event on the DC+3rd edge counting the sampling edge; digit one edge later.
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.ENTRY_STATE != 3'd0) begin
        n = i;
        break;
      end
    end
    check("bounce_latency", 32'(n), 32'(DCI + 4));
    cycles(8);
    bus.LOAD_N = 1'b1;
    cycles(10);
    check("bounce_one", 32'(chg_cnt - c0), 32'd1);
    check("bounce_digit", 32'(digits()), 32'h6000);

    // Rejected digit in A_O
    e0 = err_cnt;
    press(4'hC, 1'b0);
    check("err_pulse",  32'(err_cnt - e0), 32'd1);
    check("err_state",  32'(bus.ENTRY_STATE), 32'd1);
    check("err_digits", 32'(digits()), 32'h6000);
    press(4'd4, 1'b0);
    check("err_retry",  32'(digits()), 32'h6400);

    // Switch wiggle without press, then a long hold
    c0 = chg_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.DIGIT_IN = 4'(i);
      bus.OP_IN    = i[0];
    end
    cycles(4);
    check("wiggle_state",  32'(chg_cnt - c0), 32'd0);
    check("wiggle_digits", 32'(digits()), 32'h6400);
    check("wiggle_op",     32'(bus.OPERATOR), 32'd0);
    @(negedge clk);
    bus.DIGIT_IN = 4'd1;
    bus.LOAD_N   = 1'b0;
    cycles(10 * DCI);
    bus.LOAD_N   = 1'b1;
    cycles(10);
    check("hold_one",    32'(chg_cnt - c0), 32'd1);
    check("hold_state",  32'(bus.ENTRY_STATE), 32'd3);
    check("hold_digits", 32'(digits()), 32'h6410);
    press(4'd9, 1'b1);
    check("e2_digits", 32'(digits()), 32'h6419);
    check("e2_op",     32'(bus.OPERATOR), 32'd1);

    // 99 - 99 then clear from READY
    press(4'd0, 1'b0);
    press(4'd9, 1'b1);
    press(4'd9, 1'b1);
    press(4'd9, 1'b1);
    press(4'd9, 1'b1);
    check("e3_digits", 32'(digits()), 32'h9999);
    check("e3_op",     32'(bus.OPERATOR), 32'd1);
    check("e3_valid",  32'(bus.OPERANDS_VALID), 32'd1);
    press(4'd5, 1'b0);
    check("e3_clr_digits", 32'(digits()), 32'h0);
    check("e3_clr_op",     32'(bus.OPERATOR), 32'd0);
    check("e3_clr_valid",  32'(bus.OPERANDS_VALID), 32'd0);
    check("e3_clr_state",  32'(bus.ENTRY_STATE), 32'd0);

    // Asynchronous reset at B_T
    press(4'd1, 1'b0);
    press(4'd2, 1'b0);
    check("pre_rst_state", 32'(bus.ENTRY_STATE), 32'd2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("arst_state",  32'(bus.ENTRY_STATE), 32'd0);
    check("arst_digits", 32'(digits()), 32'h0);
    check("arst_valid",  32'(bus.OPERANDS_VALID), 32'd0);
    cycles(2);
    rst_n = 1'b1;
    cycles(3);

`ifdef BCD_ENTRY_BACKSPACE_EN
    // Backspace from READY, then simultaneous load and del
    press(4'd1, 1'b0);
    press(4'd2, 1'b0);
    press(4'd3, 1'b0);
    press(4'd4, 1'b1);
    check("bs_ready", 32'(bus.ENTRY_STATE), 32'd4);
    @(negedge clk);
    bus.DEL_N = 1'b0;
    cycles(12);
    bus.DEL_N = 1'b1;
    cycles(10);
    check("bs_state",  32'(bus.ENTRY_STATE), 32'd3);
    check("bs_digits", 32'(digits()), 32'h1230);
    check("bs_valid",  32'(bus.OPERANDS_VALID), 32'd0);
    check("bs_op",     32'(bus.OPERATOR), 32'd0);
    @(negedge clk);
    bus.DIGIT_IN = 4'd8;
    bus.OP_IN    = 1'b0;
    bus.LOAD_N   = 1'b0;
    bus.DEL_N    = 1'b0;
    cycles(12);
    bus.LOAD_N   = 1'b1;
    bus.DEL_N    = 1'b1;
    cycles(10);
    check("both_digits", 32'(digits()), 32'h1238);
    check("both_state",  32'(bus.ENTRY_STATE), 32'd4);
    check("both_valid",  32'(bus.OPERANDS_VALID), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
